eth_tx_fcs_append: RTL



---
 rtl/eth_fcs_pkg.sv | 39 +++
 rtl/eth_tx_fcs_crc.sv | 21 ++
 rtl/eth_tx_fcs_append.sv | 135 +++++++++++++
 3 files changed

// File: rtl/eth_fcs_pkg.sv
// Shared types and CRC-32 helpers for the transmit FCS stage.
// The CRC is kept MSB-first; input bytes are bit-reversed before each update.
package eth_fcs_pkg;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        PAD  = 2'd1,
        FCS  = 2'd2,
        IFG  = 2'd3
    } fcs_state_t;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;

    function automatic logic [7:0] bitrev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = d[31-i];
        return r;
    endfunction

    function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_fcs_crc.sv
// 32-bit CRC register: preset on reset or init, one byte folded in per enabled cycle.
module eth_tx_fcs_crc
    import eth_fcs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (!rst_n || init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc32_d8_next(crc, bitrev8(data));
        end
    end

endmodule

// File: rtl/eth_tx_fcs_append.sv
// Transmit framer: pads short frames, appends the 4-byte FCS LSB first,
// then holds off input for an inter-frame gap.
//   state | meaning
//   DATA  | pass input bytes through, counting them
//   PAD   | emit zero bytes until MIN_FRAME is reached
//   FCS   | emit the four FCS bytes
//   IFG   | wait for the last byte to drain, then count idle cycles
module eth_tx_fcs_append
    import eth_fcs_pkg::*;
#(
    parameter int MIN_FRAME  = 60,
    parameter int IFG_CYCLES = 12,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy
);

    localparam int IFG_W = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES + 1);
    localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES);

    fcs_state_t       state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_sat;
    logic [31:0]      count_inc;
    logic [1:0]       fcs_idx;
    logic [IFG_W-1:0] ifg_cnt;
    logic [31:0]      crc;
    logic [31:0]      fcs;
    logic [7:0]       fcs_byte;
    logic             out_free;
    logic             accept;
    logic             crc_en;
    logic             crc_init;
    logic [7:0]       crc_data;

    assign out_free  = !m_valid || m_ready;
    assign s_ready   = (state == DATA) && out_free;
    assign accept    = s_valid && s_ready;
    assign count_inc = 32'(count) + 32'd1;
    assign count_sat = (&count) ? count : count + CNT_W'(1);
    assign fcs       = ~bitrev32(crc);
    assign fcs_byte  = fcs[{fcs_idx, 3'b000} +: 8];
    assign busy      = (state != DATA) || (count != '0) || m_valid;

    assign crc_en   = accept || ((state == PAD) && out_free);
    assign crc_init = (state == FCS) && out_free && (fcs_idx == 2'd3);
    assign crc_data = (state == PAD) ? 8'h00 : s_data;

    eth_tx_fcs_crc u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init),
        .en    (crc_en),
        .data  (crc_data),
        .crc   (crc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= DATA;
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            count   <= '0;
            fcs_idx <= 2'd0;
            ifg_cnt <= '0;
        end else begin
            case (state)
                DATA: begin
                    if (accept) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        count   <= count_sat;
                        if (s_last) begin
                            fcs_idx <= 2'd0;
                            state   <= (count_inc < 32'(MIN_FRAME)) ? PAD : FCS;
                        end
                    end else if (out_free) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                end
                PAD: begin
                    if (out_free) begin
                        m_data  <= 8'h00;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        count   <= count_sat;
                        if (count_inc == 32'(MIN_FRAME)) state <= FCS;
                    end
                end
                FCS: begin
                    if (out_free) begin
                        m_data  <= fcs_byte;
                        m_valid <= 1'b1;
                        m_last  <= (fcs_idx == 2'd3);
                        fcs_idx <= fcs_idx + 2'd1;
                        if (fcs_idx == 2'd3) begin
                            count   <= '0;
                            ifg_cnt <= IFG_LOAD;
                            state   <= (IFG_CYCLES > 0) ? IFG : DATA;
                        end
                    end
                end
                IFG: begin
                    // gap timing begins only once the final FCS byte has left
                    if (m_valid) begin
                        if (m_ready) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end
                    end else if (ifg_cnt <= IFG_W'(1)) begin
                        ifg_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        ifg_cnt <= ifg_cnt - IFG_W'(1);
                    end
                end
                default: state <= DATA;
            endcase
        end
    end

endmodule
